// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//
// Drains the read port of the dual-clock memory FIFO and presents the words
// as a valid/ready stream with frame framing. A small circular buffer plus
// credit accounting hides the FIFO's one-cycle read latency, so a consumer
// that is always ready receives one word per cycle.
//
// Ports:
//   i_clk                   read-domain clock (same as the FIFO read clock)
//   i_rst_n                 asynchronous active-low reset
//   i_flush                 synchronous clear of buffer, credit and frame count
//   i_fifo_empty            FIFO empty flag (registered in the FIFO)
//   o_fifo_read_enable      FIFO read request (registered)
//   i_fifo_read_data        FIFO read data
//   i_fifo_read_data_valid  FIFO read-data qualifier, 1 cycle after request
//   o_data                  stream data
//   o_valid                 stream valid
//   i_ready                 consumer ready
//   o_last                  last word of the current frame
//   o_level                 buffer occupancy
module fifo_stream_reader #(
    parameter int M_WIDTH   = 32,
    parameter int BUF_DEPTH = 4,
    parameter int FRAME_LEN = 2048
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_flush,
    input  logic                         i_fifo_empty,
    output logic                         o_fifo_read_enable,
    input  logic [M_WIDTH-1:0]           i_fifo_read_data,
    input  logic                         i_fifo_read_data_valid,
    output logic [M_WIDTH-1:0]           o_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic                         o_last,
    output logic [$clog2(BUF_DEPTH):0]   o_level
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = $clog2(FRAME_LEN);

    logic [M_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [FW-1:0]      frame_cnt;
    logic               rd_en_q;
    logic               flush_d;

    logic               push;
    logic               pop;
    logic [CW-1:0]      count_after;
    logic [CW:0]        demand;
    logic               issue;

    // A word returning from a request made before the flush is dropped both
    // in the flush cycle and in the cycle after it.
    assign push = i_fifo_read_data_valid && !i_flush && !flush_d;
    assign pop  = o_valid && i_ready;

    // Occupancy after this edge plus the request currently in flight; a new
    // request is only issued if its returning word is guaranteed a slot.
    assign count_after = count + CW'(push) - CW'(pop);
    assign demand      = {1'b0, count_after} + (CW+1)'(rd_en_q);
    assign issue       = !i_fifo_empty && !i_flush && (demand < (CW+1)'(BUF_DEPTH));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem       <= '{default: '0};
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_cnt <= '0;
            rd_en_q   <= 1'b0;
            flush_d   <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= i_fifo_read_data;
            end
            if (i_flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                frame_cnt <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr    <= rd_ptr + 1'b1;
                    frame_cnt <= (frame_cnt == FW'(FRAME_LEN - 1)) ? '0 : frame_cnt + 1'b1;
                end
                count <= count_after;
            end
            rd_en_q <= issue;
            flush_d <= i_flush;
        end
    end

    assign o_fifo_read_enable = rd_en_q;
    assign o_valid            = (count != '0);
    assign o_data             = mem[rd_ptr];
    assign o_last             = o_valid && (frame_cnt == FW'(FRAME_LEN - 1));
    assign o_level            = count;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
//
// Bench for fifo_stream_reader. A behavioural FIFO supplies words; every word
// written into it is queued as an expected stream word. A negedge monitor
// tracks buffer occupancy and frame position from the stream rules and
// compares each handshaken word against the queue.
module tb_fifo_stream_reader;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int FL = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  flush = 1'b0;
    logic                  fifo_empty = 1'b1;
    logic                  rd_en;
    logic [W-1:0]          rdata = '0;
    logic                  dv = 1'b0;
    logic [W-1:0]          odata;
    logic                  valid;
    logic                  ready = 1'b0;
    logic                  last;
    logic [$clog2(D):0]    level;

    int checks = 0;
    int errors = 0;
    int lasts  = 0;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    int           lvl = 0;
    int           fidx = 0;
    bit           flush_d = 1'b0;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .M_WIDTH   (W),
        .BUF_DEPTH (D),
        .FRAME_LEN (FL)
    ) dut (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_flush                (flush),
        .i_fifo_empty           (fifo_empty),
        .o_fifo_read_enable     (rd_en),
        .i_fifo_read_data       (rdata),
        .i_fifo_read_data_valid (dv),
        .o_data                 (odata),
        .o_valid                (valid),
        .i_ready                (ready),
        .o_last                 (last),
        .o_level                (level)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Behavioural FIFO: 1-cycle read latency, registered empty flag.
    always @(posedge clk) begin
        dv <= 1'b0;
        if (rd_en && fifo_q.size() > 0) begin
            rdata <= fifo_q.pop_front();
            dv    <= 1'b1;
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Reference model and monitor, evaluated on the inactive edge.
    always @(negedge clk) begin
        bit           pop;
        logic [W-1:0] e;
        if (rst_n) begin
            chk("level", level, lvl);
            chk("valid", valid, lvl != 0);
            if (lvl == D) chk("rd_en_while_full", rd_en, 0);
            pop = valid && ready && !flush;
            if (pop) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got 0x%0h expected none", odata);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", odata, e);
                    chk("last", last, fidx == FL - 1);
                end
                if (last) lasts++;
                fidx = (fidx + 1) % FL;
            end
            if (flush) begin
                repeat (lvl) if (exp_q.size() > 0) void'(exp_q.pop_front());
                if (dv && exp_q.size() > 0) void'(exp_q.pop_front());
                lvl  = 0;
                fidx = 0;
            end else if (dv && flush_d) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else begin
                lvl = lvl + int'(dv) - int'(pop);
            end
            flush_d = flush;
        end
    end

    task automatic put(input logic [W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic clear_model();
        fifo_q.delete();
        exp_q.delete();
        lvl     = 0;
        fidx    = 0;
        flush_d = 1'b0;
        lasts   = 0;
    endtask

    task automatic reset_assert();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        flush = 1'b0;
        ready = 1'b0;
        clear_model();
    endtask

    task automatic reset_release();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int k;
        flush = 1'b0;
        ready = 1'b1;
        k = 0;
        while ((exp_q.size() != 0 || lvl != 0) && k < 300) begin
            run(1);
            k++;
        end
        if (k >= 300) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d words left expected 0", name, exp_q.size());
        end
        run(3);
        chk({name, "_level"}, level, 0);
        chk({name, "_valid"}, valid, 0);
    endtask

    initial begin
        int k;
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;

        // Reset values and basic drain with first-word latency.
        reset_assert();
        for (int i = 0; i < 8; i++) put(W'(i));
        @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_last", last, 0);
        chk("rst_level", level, 0);
        chk("rst_data", odata, 0);
        reset_release();
        ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("latency_not_yet", valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("latency_valid", valid, 1);
        chk("first_word", odata, 0);
        #1;
        drain("basic");

        // Backpressure: buffer saturates and requests stop.
        reset_assert();
        reset_release();
        for (int i = 0; i < 16; i++) put(W'(16'h0100 + i));
        run(20);
        @(negedge clk);
        chk("bp_level_full", level, D);
        chk("bp_rd_en_off", rd_en, 0);
        @(posedge clk);
        #1;
        drain("bp");

        // Stale empty: a single word, level never above 1.
        reset_assert();
        reset_release();
        put(32'hCAFE_0001);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stale_level_max", level <= 1, 1);
        end
        chk("stale_level_one", level, 1);
        @(posedge clk);
        #1;
        drain("stale");

        // Framing: 10 words with FRAME_LEN=4 -> o_last on words 3 and 7.
        reset_assert();
        reset_release();
        ready = 1'b1;
        for (int i = 0; i < 10; i++) put(W'(32'h2000 + i));
        drain("frame");
        chk("frame_last_count", lasts, 2);

        // Flush while a read is returning, with 2 words buffered.
        reset_assert();
        reset_release();
        for (int i = 0; i < 8; i++) put(W'(32'h3000 + i));
        k = 0;
        while (!(level == 2 && dv) && k < 30) begin
            run(1);
            k++;
        end
        chk("flush_setup_found", k < 30, 1);
        flush = 1'b1;
        run(1);
        flush = 1'b0;
        @(negedge clk);
        chk("flush_valid_low", valid, 0);
        chk("flush_rd_en_low", rd_en, 0);
        @(posedge clk);
        #1;
        drain("flush");

        // Async reset mid-stream with 3 words buffered.
        reset_assert();
        reset_release();
        for (int i = 0; i < 8; i++) put(W'(32'h4000 + i));
        k = 0;
        while (level != 3 && k < 30) begin
            run(1);
            k++;
        end
        chk("areset_setup_found", k < 30, 1);
        #3;
        rst_n = 1'b0;
        clear_model();
        #1;
        chk("areset_valid", valid, 0);
        chk("areset_rd_en", rd_en, 0);
        chk("areset_level", level, 0);
        reset_release();
        for (int i = 0; i < 5; i++) put(W'(32'h4100 + i));
        drain("areset");

        // Randomized traffic with random backpressure and occasional flush.
        for (int r = 0; r < 6; r++) begin
            reset_assert();
            reset_release();
            for (int i = 0; i < int'($urandom_range(5, 20)); i++) put($urandom);
            for (int c = 0; c < 80; c++) begin
                ready = ($urandom_range(0, 3) != 0);
                flush = ($urandom_range(0, 29) == 0);
                if ($urandom_range(0, 3) == 0) put($urandom);
                run(1);
            end
            drain("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
